// File: rtl/router_pkg.sv
// Shared constants and types for the router output FIFO slice.
// Header byte layout: [DW-1:2] payload length, [1:0] destination address.
package router_pkg;

    localparam int ROUTER_DW   = 8;
    localparam int HDR_ADDR_W  = 2;
    localparam int HDR_LEN_LSB = HDR_ADDR_W;
    localparam int HDR_LEN_MSB = ROUTER_DW - 1;

    // Per-cycle transfer classification, encoded as {read accepted, write accepted}
    typedef enum logic [1:0] {
        XFER_NONE = 2'b00,
        XFER_WR   = 2'b01,
        XFER_RD   = 2'b10,
        XFER_BOTH = 2'b11
    } xfer_e;

    function automatic xfer_e classify_xfer(input logic rd_ok, input logic wr_ok);
        return xfer_e'({rd_ok, wr_ok});
    endfunction

endpackage

// File: rtl/router_fifo_pkt_if.sv
// Handshake bundle between the router writer/reader and the per-destination FIFO.
// master drives requests and write data; slave is the FIFO itself.
interface router_fifo_pkt_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          soft_reset;
    logic          we_enb;
    logic          lfd_state;
    logic [DW-1:0] d_in;
    logic          re_enb;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [AW:0]   level;
    logic [DW-2:0] pkt_count;
    logic          pkt_last;
    logic          ovf_err;
    logic          udf_err;

    modport master (
        output soft_reset, we_enb, lfd_state, d_in, re_enb,
        input  data_out, data_valid, full, empty, almost_full,
               level, pkt_count, pkt_last, ovf_err, udf_err
    );

    modport slave (
        input  soft_reset, we_enb, lfd_state, d_in, re_enb,
        output data_out, data_valid, full, empty, almost_full,
               level, pkt_count, pkt_last, ovf_err, udf_err
    );

endinterface

// File: rtl/router_fifo_mem.sv
// Dual-port storage for the router FIFO: synchronous write, registered read data,
// plus a combinational view of the head entry's tag and length field for packet tracking.
module router_fifo_mem
    import router_pkg::*;
#(
    parameter int DW    = ROUTER_DW,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      we,
    input  logic [AW-1:0]             waddr,
    input  logic [DW:0]               wdata,
    input  logic                      re,
    input  logic [AW-1:0]             raddr,
    output logic [DW-1:0]             rdata,
    output logic                      head_tag,
    output logic [DW-1-HDR_LEN_LSB:0] head_len
);

    logic [DW:0] mem [DEPTH];

    // Storage is never cleared; only the read register follows reset/flush
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr][DW-1:0];
        end
    end

    assign head_tag = mem[raddr][DW];
    assign head_len = mem[raddr][DW-1:HDR_LEN_LSB];

endmodule

// File: rtl/router_fifo_pkt.sv
// Per-destination router output FIFO with header tagging and packet byte tracking.
// Define ROUTER_FIFO_ERR_EN to build the sticky overflow/underflow flags.
module router_fifo_pkt
    import router_pkg::*;
#(
    parameter int DW        = ROUTER_DW,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2
) (
    input  logic               clk,
    input  logic               rst,
    router_fifo_pkt_if.slave   bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   AF_LEVEL = (AW+1)'(AF_THRESH);
    localparam logic [DW-2:0] CNT_ONE  = (DW-1)'(1);

    logic [AW:0]               wptr;
    logic [AW:0]               rptr;
    logic [AW:0]               level_q;
    logic                      full_i;
    logic                      empty_i;
    logic                      wr_ok;
    logic                      rd_ok;
    xfer_e                     xfer;
    logic                      head_tag;
    logic [DW-1-HDR_LEN_LSB:0] head_len;
    logic [DW-2:0]             hdr_count;
    logic [DW-2:0]             pkt_count_q;
    logic                      pkt_last_q;
    logic                      data_valid_q;
    logic [DW-1:0]             rdata;

    // Extra pointer MSB distinguishes full from empty when the addresses match
    assign empty_i = (wptr == rptr);
    assign full_i  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    assign wr_ok = bus.we_enb && !full_i && !bus.soft_reset;
    assign rd_ok = bus.re_enb && !empty_i && !bus.soft_reset;
    assign xfer  = classify_xfer(rd_ok, wr_ok);

    router_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk      (clk),
        .rst      (rst),
        .clr      (bus.soft_reset),
        .we       (wr_ok),
        .waddr    (wptr[AW-1:0]),
        .wdata    ({bus.lfd_state, bus.d_in}),
        .re       (rd_ok),
        .raddr    (rptr[AW-1:0]),
        .rdata    (rdata),
        .head_tag (head_tag),
        .head_len (head_len)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
        end else if (bus.soft_reset) begin
            wptr    <= '0;
            rptr    <= '0;
            level_q <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr <= rptr + 1'b1;
            end
            unique case (xfer)
                XFER_WR:  level_q <= level_q + 1'b1;
                XFER_RD:  level_q <= level_q - 1'b1;
                default:  level_q <= level_q;
            endcase
        end
    end

    // Header count covers the payload bytes plus the trailing parity byte
    assign hdr_count = {1'b0, head_len} + CNT_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count_q  <= '0;
            pkt_last_q   <= 1'b0;
            data_valid_q <= 1'b0;
        end else if (bus.soft_reset) begin
            pkt_count_q  <= '0;
            pkt_last_q   <= 1'b0;
            data_valid_q <= 1'b0;
        end else begin
            data_valid_q <= rd_ok;
            pkt_last_q   <= 1'b0;
            if (rd_ok) begin
                if (head_tag) begin
                    pkt_count_q <= hdr_count;
                end else if (pkt_count_q != '0) begin
                    pkt_count_q <= pkt_count_q - 1'b1;
                    pkt_last_q  <= (pkt_count_q == CNT_ONE);
                end
            end
        end
    end

`ifdef ROUTER_FIFO_ERR_EN
    logic ovf_q;
    logic udf_q;

    // Flags record the attempt, not just accepted traffic, and hold until a flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (bus.soft_reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (bus.we_enb && full_i) begin
                ovf_q <= 1'b1;
            end
            if (bus.re_enb && empty_i) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign bus.ovf_err = ovf_q;
    assign bus.udf_err = udf_q;
`else
    assign bus.ovf_err = 1'b0;
    assign bus.udf_err = 1'b0;
`endif

    assign bus.data_out    = rdata;
    assign bus.data_valid  = data_valid_q;
    assign bus.full        = full_i;
    assign bus.empty       = empty_i;
    assign bus.almost_full = (level_q >= AF_LEVEL);
    assign bus.level       = level_q;
    assign bus.pkt_count   = pkt_count_q;
    assign bus.pkt_last    = pkt_last_q;

endmodule
